// File: rtl/bsg_axil_demux_n.sv
// AXI-lite 1-to-N address demux; one decode cycle, then AW/W/AR forwarded; one outstanding txn per direction.
// Backpressure: ready/valid pass through to the selected port only; new AW/AR stall until the FSM is IDLE.
// BSG_AXIL_DEMUX_DECERR_EN: address misses are answered internally with DECERR instead of default_port_p.
module bsg_axil_demux_n #(
    parameter int addr_width_p   = 32,
    parameter int data_width_p   = 32,
    parameter int num_masters_p  = 4,
    parameter logic [num_masters_p*addr_width_p-1:0] base_addr_p =
        {32'h1000_0000, 32'h2000_0000, 32'h0020_0000, 32'h0},
    parameter logic [num_masters_p*addr_width_p-1:0] mask_addr_p =
        {32'hFFF0_0000, 32'hFC00_0000, 32'hFFE0_0000, 32'hFFE0_0000},
    parameter int default_port_p = 0
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,

    input  logic [addr_width_p-1:0]                  s_axil_awaddr,
    input  logic [2:0]                               s_axil_awprot,
    input  logic                                     s_axil_awvalid,
    output logic                                     s_axil_awready,
    input  logic [data_width_p-1:0]                  s_axil_wdata,
    input  logic [data_width_p/8-1:0]                s_axil_wstrb,
    input  logic                                     s_axil_wvalid,
    output logic                                     s_axil_wready,
    output logic [1:0]                               s_axil_bresp,
    output logic                                     s_axil_bvalid,
    input  logic                                     s_axil_bready,
    input  logic [addr_width_p-1:0]                  s_axil_araddr,
    input  logic [2:0]                               s_axil_arprot,
    input  logic                                     s_axil_arvalid,
    output logic                                     s_axil_arready,
    output logic [data_width_p-1:0]                  s_axil_rdata,
    output logic [1:0]                               s_axil_rresp,
    output logic                                     s_axil_rvalid,
    input  logic                                     s_axil_rready,

    output logic [num_masters_p*addr_width_p-1:0]    m_axil_awaddr,
    output logic [num_masters_p*3-1:0]               m_axil_awprot,
    output logic [num_masters_p-1:0]                 m_axil_awvalid,
    input  logic [num_masters_p-1:0]                 m_axil_awready,
    output logic [num_masters_p*data_width_p-1:0]    m_axil_wdata,
    output logic [num_masters_p*data_width_p/8-1:0]  m_axil_wstrb,
    output logic [num_masters_p-1:0]                 m_axil_wvalid,
    input  logic [num_masters_p-1:0]                 m_axil_wready,
    input  logic [num_masters_p*2-1:0]               m_axil_bresp,
    input  logic [num_masters_p-1:0]                 m_axil_bvalid,
    output logic [num_masters_p-1:0]                 m_axil_bready,
    output logic [num_masters_p*addr_width_p-1:0]    m_axil_araddr,
    output logic [num_masters_p*3-1:0]               m_axil_arprot,
    output logic [num_masters_p-1:0]                 m_axil_arvalid,
    input  logic [num_masters_p-1:0]                 m_axil_arready,
    input  logic [num_masters_p*data_width_p-1:0]    m_axil_rdata,
    input  logic [num_masters_p*2-1:0]               m_axil_rresp,
    input  logic [num_masters_p-1:0]                 m_axil_rvalid,
    output logic [num_masters_p-1:0]                 m_axil_rready
);

    typedef enum logic [1:0] {IDLE, FWD, RESP} state_e;

    state_e wr_state, wr_next, rd_state, rd_next;
    logic [num_masters_p-1:0] wr_sel, rd_sel;
    logic wr_miss, rd_miss;
    logic aw_done, w_done;
    logic aw_hs, w_hs, ar_hs;
    logic sel_awready, sel_wready, sel_bvalid, sel_arready, sel_rvalid;
    logic [1:0] sel_bresp, sel_rresp;
    logic [data_width_p-1:0] sel_rdata;

    // Iterating high to low lets the lowest matching index overwrite any other hit.
    function automatic logic [num_masters_p-1:0] decode(input logic [addr_width_p-1:0] addr);
        logic [num_masters_p-1:0] hit;
        hit = '0;
        for (int i = num_masters_p - 1; i >= 0; i--) begin
            if ((addr & mask_addr_p[i*addr_width_p +: addr_width_p])
                    == base_addr_p[i*addr_width_p +: addr_width_p]) begin
                hit    = '0;
                hit[i] = 1'b1;
            end
        end
`ifndef BSG_AXIL_DEMUX_DECERR_EN
        if (hit == '0) hit[default_port_p] = 1'b1;
`endif
        return hit;
    endfunction

`ifdef BSG_AXIL_DEMUX_DECERR_EN
    // An empty select outside IDLE marks a transaction the demux answers itself.
    assign wr_miss = ~|wr_sel;
    assign rd_miss = ~|rd_sel;
`else
    assign wr_miss = 1'b0;
    assign rd_miss = 1'b0;
`endif

    assign m_axil_awaddr = {num_masters_p{s_axil_awaddr}};
    assign m_axil_awprot = {num_masters_p{s_axil_awprot}};
    assign m_axil_wdata  = {num_masters_p{s_axil_wdata}};
    assign m_axil_wstrb  = {num_masters_p{s_axil_wstrb}};
    assign m_axil_araddr = {num_masters_p{s_axil_araddr}};
    assign m_axil_arprot = {num_masters_p{s_axil_arprot}};

    assign sel_awready = |(m_axil_awready & wr_sel);
    assign sel_wready  = |(m_axil_wready  & wr_sel);
    assign sel_bvalid  = |(m_axil_bvalid  & wr_sel);
    assign sel_arready = |(m_axil_arready & rd_sel);
    assign sel_rvalid  = |(m_axil_rvalid  & rd_sel);

    always_comb begin
        sel_bresp = '0;
        sel_rresp = '0;
        sel_rdata = '0;
        for (int i = 0; i < num_masters_p; i++) begin
            if (wr_sel[i]) sel_bresp = sel_bresp | m_axil_bresp[2*i +: 2];
            if (rd_sel[i]) begin
                sel_rresp = sel_rresp | m_axil_rresp[2*i +: 2];
                sel_rdata = sel_rdata | m_axil_rdata[i*data_width_p +: data_width_p];
            end
        end
    end

    assign aw_hs = s_axil_awvalid & s_axil_awready;
    assign w_hs  = s_axil_wvalid  & s_axil_wready;
    assign ar_hs = s_axil_arvalid & s_axil_arready;

    // ---------------- write path ----------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) wr_state <= IDLE;
        else         wr_state <= wr_next;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_sel  <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (wr_state == IDLE && s_axil_awvalid) begin
            wr_sel  <= decode(s_axil_awaddr);
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
        end
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            IDLE:    if (s_axil_awvalid) wr_next = FWD;
            FWD:     if ((aw_done | aw_hs) && (w_done | w_hs)) wr_next = RESP;
            RESP:    if (s_axil_bvalid && s_axil_bready) wr_next = IDLE;
            default: wr_next = IDLE;
        endcase
    end

    always_comb begin
        s_axil_awready = 1'b0;
        s_axil_wready  = 1'b0;
        s_axil_bvalid  = 1'b0;
        s_axil_bresp   = 2'b00;
        m_axil_awvalid = '0;
        m_axil_wvalid  = '0;
        m_axil_bready  = '0;
        case (wr_state)
            FWD: begin
                s_axil_awready = ~aw_done & (wr_miss | sel_awready);
                s_axil_wready  = ~w_done  & (wr_miss | sel_wready);
                m_axil_awvalid = wr_sel & {num_masters_p{s_axil_awvalid & ~aw_done}};
                m_axil_wvalid  = wr_sel & {num_masters_p{s_axil_wvalid  & ~w_done}};
            end
            RESP: begin
                s_axil_bvalid = wr_miss | sel_bvalid;
                s_axil_bresp  = wr_miss ? 2'b11 : sel_bresp;
                m_axil_bready = wr_sel & {num_masters_p{s_axil_bready}};
            end
            default: ;
        endcase
    end

    // ---------------- read path ----------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) rd_state <= IDLE;
        else         rd_state <= rd_next;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)                                   rd_sel <= '0;
        else if (rd_state == IDLE && s_axil_arvalid)   rd_sel <= decode(s_axil_araddr);
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            IDLE:    if (s_axil_arvalid) rd_next = FWD;
            FWD:     if (ar_hs) rd_next = RESP;
            RESP:    if (s_axil_rvalid && s_axil_rready) rd_next = IDLE;
            default: rd_next = IDLE;
        endcase
    end

    always_comb begin
        s_axil_arready = 1'b0;
        s_axil_rvalid  = 1'b0;
        s_axil_rresp   = 2'b00;
        s_axil_rdata   = '0;
        m_axil_arvalid = '0;
        m_axil_rready  = '0;
        case (rd_state)
            FWD: begin
                s_axil_arready = rd_miss | sel_arready;
                m_axil_arvalid = rd_sel & {num_masters_p{s_axil_arvalid}};
            end
            RESP: begin
                s_axil_rvalid = rd_miss | sel_rvalid;
                s_axil_rresp  = rd_miss ? 2'b11 : sel_rresp;
                s_axil_rdata  = rd_miss ? '0 : sel_rdata;
                m_axil_rready = rd_sel & {num_masters_p{s_axil_rready}};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bsg_axil_demux_n.sv
// Directed bench for bsg_axil_demux_n with the default 4-port address map.
module tb_bsg_axil_demux_n;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset_i;
    always #5 clk = ~clk;

    logic [AW-1:0]     s_axil_awaddr, s_axil_araddr;
    logic [2:0]        s_axil_awprot, s_axil_arprot;
    logic              s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
    logic [DW-1:0]     s_axil_wdata, s_axil_rdata;
    logic [DW/8-1:0]   s_axil_wstrb;
    logic [1:0]        s_axil_bresp, s_axil_rresp;
    logic              s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready;
    logic              s_axil_rvalid, s_axil_rready;

    logic [N*AW-1:0]   m_axil_awaddr, m_axil_araddr;
    logic [N*3-1:0]    m_axil_awprot, m_axil_arprot;
    logic [N-1:0]      m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
    logic [N*DW-1:0]   m_axil_wdata, m_axil_rdata;
    logic [N*DW/8-1:0] m_axil_wstrb;
    logic [N*2-1:0]    m_axil_bresp, m_axil_rresp;
    logic [N-1:0]      m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
    logic [N-1:0]      m_axil_rvalid, m_axil_rready;

    int n_cmp = 0;
    int n_err = 0;

    bsg_axil_demux_n dut (
        .clk_i(clk), .reset_i(reset_i),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
        .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
        .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
        .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
        .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset_i = 1'b1;
        s_axil_awaddr = '0; s_axil_awprot = 3'd0; s_axil_awvalid = 1'b0;
        s_axil_wdata = '0;  s_axil_wstrb = '0;    s_axil_wvalid = 1'b0;
        s_axil_bready = 1'b0;
        s_axil_araddr = '0; s_axil_arprot = 3'd0; s_axil_arvalid = 1'b0;
        s_axil_rready = 1'b0;
        m_axil_awready = '0; m_axil_wready = '0; m_axil_bresp = '0; m_axil_bvalid = '0;
        m_axil_arready = '0; m_axil_rdata = '0;  m_axil_rresp = '0; m_axil_rvalid = '0;

        // Reset state
        tick(); tick();
        settle();
        chk("rst_awready", s_axil_awready, 0);
        chk("rst_arready", s_axil_arready, 0);
        chk("rst_bvalid",  s_axil_bvalid, 0);
        chk("rst_rvalid",  s_axil_rvalid, 0);
        chk("rst_bresp",   s_axil_bresp, 0);
        chk("rst_rdata",   s_axil_rdata, 0);
        chk("rst_m_awvalid", m_axil_awvalid, 0);
        chk("rst_m_arvalid", m_axil_arvalid, 0);
        reset_i = 1'b0;
        m_axil_awready = 4'hF; m_axil_wready = 4'hF; m_axil_arready = 4'hF;
        tick();

        // Write 0x2000_0010 -> port 2, W two cycles ahead of AW
        s_axil_wvalid = 1'b1; s_axil_wdata = 32'hDEAD_BEEF; s_axil_wstrb = 4'hF;
        settle();
        chk("w_early_wready", s_axil_wready, 0);
        chk("w_early_m_wvalid", m_axil_wvalid, 0);
        tick(); settle();
        chk("w_early_wready2", s_axil_wready, 0);
        tick();
        s_axil_awvalid = 1'b1; s_axil_awaddr = 32'h2000_0010;
        settle();
        chk("aw_idle_awready", s_axil_awready, 0);
        chk("aw_idle_m_awvalid", m_axil_awvalid, 0);
        tick(); settle();
        chk("p2_m_awvalid", m_axil_awvalid, 4'b0100);
        chk("p2_m_wvalid", m_axil_wvalid, 4'b0100);
        chk("p2_awready", s_axil_awready, 1);
        chk("p2_wready", s_axil_wready, 1);
        chk("p2_awaddr", m_axil_awaddr[2*AW +: AW], 32'h2000_0010);
        chk("p2_wdata", m_axil_wdata[2*DW +: DW], 32'hDEAD_BEEF);
        tick();
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        m_axil_bvalid = 4'hF; m_axil_bresp = 8'b10_00_10_10;
        settle();
        chk("p2_resp_awready", s_axil_awready, 0);
        chk("p2_bvalid", s_axil_bvalid, 1);
        chk("p2_bresp", s_axil_bresp, 2'b00);
        chk("p2_bready_idle", m_axil_bready, 0);
        s_axil_bready = 1'b1;
        settle();
        chk("p2_bready", m_axil_bready, 4'b0100);
        tick();
        m_axil_bvalid = '0; s_axil_bready = 1'b0;
        settle();
        chk("p2_done_bvalid", s_axil_bvalid, 0);

        // Concurrent read 0x4 (port 0) and write 0x1000_0000 (port 3)
        s_axil_arvalid = 1'b1; s_axil_araddr = 32'h0000_0004;
        s_axil_awvalid = 1'b1; s_axil_awaddr = 32'h1000_0000;
        s_axil_wvalid = 1'b1;  s_axil_wdata = 32'h1234_5678;
        settle();
        chk("cc_arready_idle", s_axil_arready, 0);
        tick(); settle();
        chk("cc_m_arvalid", m_axil_arvalid, 4'b0001);
        chk("cc_m_awvalid", m_axil_awvalid, 4'b1000);
        chk("cc_m_wvalid", m_axil_wvalid, 4'b1000);
        tick();
        s_axil_arvalid = 1'b0; s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        m_axil_rvalid = 4'b0001; m_axil_rdata[0 +: DW] = 32'hCAFE_0004; m_axil_rresp = '0;
        m_axil_bvalid = 4'b1000; m_axil_bresp = '0;
        s_axil_rready = 1'b1; s_axil_bready = 1'b0;
        settle();
        chk("cc_rvalid", s_axil_rvalid, 1);
        chk("cc_rdata", s_axil_rdata, 32'hCAFE_0004);
        chk("cc_bvalid", s_axil_bvalid, 1);
        tick();
        m_axil_rvalid = '0; s_axil_rready = 1'b0;
        settle();
        chk("cc_rvalid_done", s_axil_rvalid, 0);
        chk("cc_bvalid_held", s_axil_bvalid, 1);
        s_axil_bready = 1'b1;
        tick();
        m_axil_bvalid = '0; s_axil_bready = 1'b0;
        settle();
        chk("cc_bvalid_done", s_axil_bvalid, 0);

        // Read of unmapped 0x3000_0000
        m_axil_rdata = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h0000_0055};
        s_axil_arvalid = 1'b1; s_axil_araddr = 32'h3000_0000;
        tick(); settle();
`ifdef BSG_AXIL_DEMUX_DECERR_EN
        chk("miss_m_arvalid", m_axil_arvalid, 0);
        chk("miss_arready", s_axil_arready, 1);
        tick();
        s_axil_arvalid = 1'b0; m_axil_rvalid = 4'hF; s_axil_rready = 1'b1;
        settle();
        chk("miss_rvalid", s_axil_rvalid, 1);
        chk("miss_rresp", s_axil_rresp, 2'b11);
        chk("miss_rdata", s_axil_rdata, 0);
        chk("miss_m_rready", m_axil_rready, 0);
`else
        chk("miss_m_arvalid", m_axil_arvalid, 4'b0001);
        chk("miss_arready", s_axil_arready, 1);
        tick();
        s_axil_arvalid = 1'b0; m_axil_rvalid = 4'b0001; s_axil_rready = 1'b1;
        settle();
        chk("miss_rvalid", s_axil_rvalid, 1);
        chk("miss_rdata", s_axil_rdata, 32'h0000_0055);
        chk("miss_m_rready", m_axil_rready, 4'b0001);
`endif
        tick();
        m_axil_rvalid = '0; s_axil_rready = 1'b0;

        // Port 1 holds rvalid under rready=0 while a second AR waits
        s_axil_arvalid = 1'b1; s_axil_araddr = 32'h0020_0000;
        tick(); settle();
        chk("p1_m_arvalid", m_axil_arvalid, 4'b0010);
        tick();
        s_axil_araddr = 32'h0000_0004;
        m_axil_rvalid = 4'b0010; m_axil_rdata[DW +: DW] = 32'hA5A5_0001; m_axil_rresp = '0;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("hold_rvalid", s_axil_rvalid, 1);
            chk("hold_rdata", s_axil_rdata, 32'hA5A5_0001);
            chk("hold_arready", s_axil_arready, 0);
            chk("hold_m_arvalid", m_axil_arvalid, 0);
            tick();
        end
        s_axil_rready = 1'b1;
        settle();
        chk("hold_m_rready", m_axil_rready, 4'b0010);
        tick();
        s_axil_rready = 1'b0; m_axil_rvalid = '0;
        settle();
        chk("b2b_idle_arready", s_axil_arready, 0);
        chk("b2b_idle_rvalid", s_axil_rvalid, 0);
        tick(); settle();
        chk("b2b_m_arvalid", m_axil_arvalid, 4'b0001);
        chk("b2b_arready", s_axil_arready, 1);
        tick();
        s_axil_arvalid = 1'b0; m_axil_rvalid = 4'b0001; m_axil_rdata[0 +: DW] = 32'h0000_0077;
        s_axil_rready = 1'b1;
        settle();
        chk("b2b_rdata", s_axil_rdata, 32'h0000_0077);
        tick();
        m_axil_rvalid = '0; s_axil_rready = 1'b0;

        // Reset while the write FSM sits in RESP
        s_axil_awvalid = 1'b1; s_axil_awaddr = 32'h2000_0010; s_axil_wvalid = 1'b1;
        tick(); tick();
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        m_axil_bvalid = 4'b0100; m_axil_bresp = '0; s_axil_bready = 1'b1;
        settle();
        chk("pre_rst_bvalid", s_axil_bvalid, 1);
        reset_i = 1'b1;
        settle();
        chk("mid_rst_bvalid", s_axil_bvalid, 0);
        chk("mid_rst_m_bready", m_axil_bready, 0);
        chk("mid_rst_awready", s_axil_awready, 0);
        tick(); settle();
        chk("mid_rst_bvalid2", s_axil_bvalid, 0);
        reset_i = 1'b0; m_axil_bvalid = '0; s_axil_bready = 1'b0;
        tick();

        // Write 0x0020_0000 -> port 1, AW ahead of W
        s_axil_awvalid = 1'b1; s_axil_awaddr = 32'h0020_0000; s_axil_wdata = 32'h0000_600D;
        tick(); settle();
        chk("p1_m_awvalid", m_axil_awvalid, 4'b0010);
        chk("p1_m_wvalid_none", m_axil_wvalid, 0);
        chk("p1_awready", s_axil_awready, 1);
        tick();
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b1;
        settle();
        chk("p1_m_awvalid_done", m_axil_awvalid, 0);
        chk("p1_m_wvalid", m_axil_wvalid, 4'b0010);
        chk("p1_wready", s_axil_wready, 1);
        chk("p1_bvalid_early", s_axil_bvalid, 0);
        tick();
        s_axil_wvalid = 1'b0; m_axil_bvalid = 4'b0110; m_axil_bresp = 8'b00_11_00_00;
        settle();
        chk("p1_bvalid", s_axil_bvalid, 1);
        chk("p1_bresp", s_axil_bresp, 2'b00);
        s_axil_bready = 1'b1;
        tick();
        m_axil_bvalid = '0; s_axil_bready = 1'b0;
        settle();
        chk("p1_done_bvalid", s_axil_bvalid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bsg_axil_demux_n.md
BSG_AXIL_DEMUX_N -- requirements
Module: bsg_axil_demux_n

Interface
REQ-001 SHALL have parameter addr_width_p, default 32: AXI-lite address width.
REQ-002 SHALL have parameter data_width_p, default 32: AXI-lite data width, a multiple of 8.
REQ-003 SHALL have parameter num_masters_p, default 4: number of downstream ports, range 2..16.
REQ-004 SHALL have parameter base_addr_p, default {32'h1000_0000, 32'h2000_0000, 32'h0020_0000, 32'h0}: per-port base address, port 0 in the LSBs.
REQ-005 SHALL have parameter mask_addr_p, default {32'hFFF0_0000, 32'hFC00_0000, 32'hFFE0_0000, 32'hFFE0_0000}: per-port match mask.
REQ-006 SHALL have parameter default_port_p, default 0: miss target when decode-error generation is compiled out.
REQ-007 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-008 SHALL have port reset_i, input, 1 bit: reset, asynchronous and active-high.
REQ-009 SHALL have s_axil_aw{addr,prot,valid}, inputs, widths addr_width_p/3/1, and s_axil_awready, output, 1 bit: upstream write address.
REQ-010 SHALL have s_axil_w{data,strb,valid}, inputs, widths data_width_p/data_width_p/8/1, and s_axil_wready, output, 1 bit: upstream write data.
REQ-011 SHALL have s_axil_b{resp,valid}, outputs, widths 2/1, and s_axil_bready, input, 1 bit: upstream write response.
REQ-012 SHALL have s_axil_ar{addr,prot,valid}, inputs, and s_axil_arready, output: upstream read address.
REQ-013 SHALL have s_axil_r{data,resp,valid}, outputs, and s_axil_rready, input: upstream read data.
REQ-014 SHALL have m_axil_* ports, each the s_axil_* counterpart with opposite direction, packed num_masters_p times with port i in slice i.

Function
REQ-015 SHALL decode port i as a hit when (addr & mask_i) == base_i; on multiple hits the lowest index SHALL win.
REQ-016 SHALL run independent write and read FSMs, allowing concurrent read and write traffic; arvalid and awvalid need not be mutually exclusive.
REQ-017 Write FSM states SHALL be IDLE, FWD and RESP.
REQ-018 Write FSM in IDLE: on s_axil_awvalid it SHALL register the decoded one-hot write select and go to FWD; awready SHALL be 0 in IDLE, giving one cycle of decode latency.
REQ-019 Write FSM in FWD: it SHALL forward AW and W to the selected port only and track aw_done and w_done independently in either order or in the same cycle; when both are done it SHALL go to RESP.
REQ-020 Write FSM in RESP: it SHALL mux the selected bvalid/bresp upstream, route bready to the selected port only, and return to IDLE on the bvalid&bready cycle.
REQ-021 Read FSM states SHALL be IDLE, FWD and RESP.
REQ-022 Read FSM SHALL register the decode in IDLE, forward AR in FWD until the arready handshake, and in RESP mux rdata/rresp/rvalid, returning to IDLE on rvalid&rready.
REQ-023 SHALL allow one outstanding transaction per direction; new aw/ar SHALL be stalled (ready=0) until the FSM returns to IDLE.
REQ-024 Non-selected ports SHALL see valid=0 and ready=0; address, data, prot and strb SHALL be broadcast to all ports.
REQ-025 Upstream ready/valid outputs SHALL be 0 whenever the corresponding FSM is not in the matching state.
REQ-026 Each FSM SHALL be able to return to IDLE and accept a new request with awready/arready back-to-back, so the minimum turnaround is 1 idle cycle per transaction.

Reset
REQ-027 While reset_i is high, both FSMs SHALL be IDLE, selects 0, and every valid/ready output 0.
REQ-028 Reset asserted mid-transaction SHALL abandon the transaction with no response generated.
REQ-029 Data outputs SHALL be don't-care while the associated valid is 0; bresp, rresp and rdata SHALL reset to 0.

Configuration
REQ-030 With BSG_AXIL_DEMUX_DECERR_EN defined, a write that misses all ports SHALL consume AW and W internally (ready=1 in FWD) and then return bresp=2'b11.
REQ-031 With BSG_AXIL_DEMUX_DECERR_EN defined, a read that misses all ports SHALL complete AR internally and return rdata=0 with rresp=2'b11; no m_axil valid SHALL assert.
REQ-032 With BSG_AXIL_DEMUX_DECERR_EN undefined, misses SHALL route to default_port_p.

Verification
REQ-033 Write to 0x2000_0010 with data 0xDEADBEEF, W presented 2 cycles before AW -> only port 2 sees awvalid/wvalid; port 2 bresp=0 reaches upstream; FSM returns to IDLE.
REQ-034 Concurrent read of 0x0000_0004 and write to 0x1000_0000 in the same cycle -> port 0 ar and port 3 aw both issue; both responses complete independently.
REQ-035 Read of 0x3000_0000 with the macro defined -> rresp=2'b11, rdata=0, no m_axil_arvalid; with the macro undefined -> port 0 receives arvalid.
REQ-036 Port 1 holds rvalid with rready=0 for 5 cycles -> rdata held stable upstream; a second arvalid is stalled with arready=0 until the handshake.
REQ-037 reset_i pulsed high while the write FSM is in RESP -> all outputs 0 immediately; the next write to 0x20_0000 completes normally on port 1.
